// File: rtl/talco_tb_cigar_collector.sv
// talco_tb_cigar_collector
// Receiving end of the TALCO-XDrop traceback stream. Taps the aligner's
// traceback pointers, run-length encodes them into CIGAR records
// {op, len, last} and buffers the records in a small FIFO behind a
// valid/ready interface. Per tile it also tallies the ref/query characters
// consumed so the host can cross-check the next-tile addresses.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   traceback         aligner traceback phase active
//   tb_valid          tb_pointer valid this cycle
//   tb_pointer        00=M (diag), 01=I (query only), 10=D (ref only), 11=reserved
//   commit            one-cycle pulse, end of tile traceback
//   cigar_valid       FIFO head valid
//   cigar_ready       consumer accepts head
//   cigar_op/len/last head record fields (all zero while the FIFO is empty)
//   ref_consumed      ref chars in current/last tile
//   query_consumed    query chars in current/last tile
//   counts_valid      one-cycle pulse when tile totals are final
//   overflow          sticky: record dropped on full FIFO
//   protocol_err      sticky: reserved pointer, or tb_valid during FLUSH
//   cigar_char        (only with TALCO_CIGAR_CHAR_EN) ASCII of the head op
//
// Optional feature macro: TALCO_CIGAR_CHAR_EN

module talco_tb_cigar_collector #(
  parameter int REF_LEN_WIDTH   = 16,
  parameter int QUERY_LEN_WIDTH = 16,
  parameter int RUN_WIDTH       = 12,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       traceback,
  input  logic                       tb_valid,
  input  logic [1:0]                 tb_pointer,
  input  logic                       commit,
  output logic                       cigar_valid,
  input  logic                       cigar_ready,
  output logic [1:0]                 cigar_op,
  output logic [RUN_WIDTH-1:0]       cigar_len,
  output logic                       cigar_last,
  output logic [REF_LEN_WIDTH-1:0]   ref_consumed,
  output logic [QUERY_LEN_WIDTH-1:0] query_consumed,
  output logic                       counts_valid,
  output logic                       overflow,
  output logic                       protocol_err
`ifdef TALCO_CIGAR_CHAR_EN
  ,
  output logic [7:0]                 cigar_char
`endif
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int RECW = RUN_WIDTH + 3;
  localparam logic [RUN_WIDTH-1:0] RUN_MAX = '1;
  localparam logic [1:0] OP_M   = 2'b00;
  localparam logic [1:0] OP_I   = 2'b01;
  localparam logic [1:0] OP_D   = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  typedef enum logic [1:0] {IDLE, COLLECT, FLUSH} state_t;

  state_t               state, state_next;
  logic                 run_active, run_active_next;
  logic [1:0]           run_op, run_op_next;
  logic [RUN_WIDTH-1:0] run_len, run_len_next;

  logic                 accept, brk, ptr_err, empty_commit, tile_clear;
  logic                 ref_inc, query_inc, counts_valid_next;
  logic                 push;
  logic [1:0]           push_op;
  logic [RUN_WIDTH-1:0] push_len;
  logic                 push_last;

  logic [RECW-1:0]      mem [FIFO_DEPTH];
  logic [AW:0]          wr_ptr, rd_ptr;
  logic                 fifo_empty, fifo_full, pop, wr_en;
  logic [RECW-1:0]      head;

  // Pointer acceptance and character accounting. FLUSH never accepts a
  // pointer; a break is a pointer that cannot extend the current run,
  // either because the op differs or the run length is saturated.
  always_comb begin
    accept       = tb_valid & traceback & (tb_pointer != OP_RSV) & (state != FLUSH);
    brk          = accept & run_active & ((tb_pointer != run_op) | (run_len == RUN_MAX));
    ref_inc      = accept & (tb_pointer != OP_I);
    query_inc    = accept & (tb_pointer != OP_D);
    empty_commit = commit & (state != FLUSH) & ~accept & ~run_active;
    tile_clear   = (accept & (state == IDLE)) | empty_commit;
  end

  // Next-state, run register update and FIFO push selection. A commit that
  // coincides with a break can only push the old run this cycle, so the
  // closing record of the new run is deferred to the single FLUSH cycle.
  always_comb begin
    state_next        = state;
    run_active_next   = run_active;
    run_op_next       = run_op;
    run_len_next      = run_len;
    push              = 1'b0;
    push_op           = OP_M;
    push_len          = '0;
    push_last         = 1'b0;
    counts_valid_next = 1'b0;
    ptr_err           = 1'b0;

    case (state)
      FLUSH: begin
        push              = 1'b1;
        push_op           = run_op;
        push_len          = run_len;
        push_last         = 1'b1;
        counts_valid_next = 1'b1;
        run_active_next   = 1'b0;
        run_op_next       = OP_M;
        run_len_next      = '0;
        state_next        = IDLE;
        ptr_err           = tb_valid;
      end
      default: begin
        ptr_err = tb_valid & traceback & (tb_pointer == OP_RSV);
        if (accept) begin
          if (!run_active || brk) begin
            run_active_next = 1'b1;
            run_op_next     = tb_pointer;
            run_len_next    = RUN_WIDTH'(1);
          end else begin
            run_len_next = run_len + RUN_WIDTH'(1);
          end
          if (state == IDLE) state_next = COLLECT;
        end
        if (brk) begin
          push      = 1'b1;
          push_op   = run_op;
          push_len  = run_len;
          push_last = 1'b0;
        end
        if (commit) begin
          if (brk) begin
            state_next = FLUSH;
          end else begin
            push              = 1'b1;
            push_last         = 1'b1;
            counts_valid_next = 1'b1;
            if (run_active_next) begin
              push_op  = run_op_next;
              push_len = run_len_next;
            end
            run_active_next = 1'b0;
            run_op_next     = OP_M;
            run_len_next    = '0;
            state_next      = IDLE;
          end
        end
      end
    endcase
  end

  // State, run register, tile counters and sticky flags. counts_valid is
  // registered so that it lines up with the final counter values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      run_active     <= 1'b0;
      run_op         <= OP_M;
      run_len        <= '0;
      ref_consumed   <= '0;
      query_consumed <= '0;
      counts_valid   <= 1'b0;
      overflow       <= 1'b0;
      protocol_err   <= 1'b0;
    end else begin
      state        <= state_next;
      run_active   <= run_active_next;
      run_op       <= run_op_next;
      run_len      <= run_len_next;
      counts_valid <= counts_valid_next;
      if (tile_clear) begin
        ref_consumed   <= REF_LEN_WIDTH'(ref_inc);
        query_consumed <= QUERY_LEN_WIDTH'(query_inc);
      end else begin
        if (ref_inc)   ref_consumed   <= ref_consumed + REF_LEN_WIDTH'(1);
        if (query_inc) query_consumed <= query_consumed + QUERY_LEN_WIDTH'(1);
      end
      if (push && fifo_full && !pop) overflow <= 1'b1;
      if (ptr_err) protocol_err <= 1'b1;
    end
  end

  // Record FIFO flags. The extra pointer bit separates full from empty; a
  // push into a full FIFO still lands when the head is popped the same cycle.
  always_comb begin
    fifo_empty = (wr_ptr == rd_ptr);
    fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    pop        = ~fifo_empty & cigar_ready;
    wr_en      = push & (~fifo_full | pop);
    head       = mem[rd_ptr[AW-1:0]];
  end

  // FIFO pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)   rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // FIFO storage; contents are only observable through the gated head.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= {push_op, push_len, push_last};
  end

  // Head record outputs, forced to zero while nothing is buffered.
  always_comb begin
    cigar_valid = ~fifo_empty;
    cigar_op    = fifo_empty ? 2'b00 : head[RECW-1 -: 2];
    cigar_len   = fifo_empty ? '0 : head[RUN_WIDTH:1];
    cigar_last  = fifo_empty ? 1'b0 : head[0];
  end

`ifdef TALCO_CIGAR_CHAR_EN
  // ASCII view of the head op for debug consoles.
  always_comb begin
    cigar_char = 8'h00;
    if (cigar_valid) begin
      case (cigar_op)
        OP_M:    cigar_char = 8'h4D;
        OP_I:    cigar_char = 8'h49;
        OP_D:    cigar_char = 8'h44;
        default: cigar_char = 8'h00;
      endcase
    end
  end
`endif

endmodule
